pwm_multi: RTL and testbench

Multi-channel, parametrised PWM generator: one shared period counter drives CHANNELS independent compare channels. It adds a programmable period, edge-aligned and center-aligned counting modes, per-channel output inversion, and glitch-free double-buffered updates that take effect only at a period boundary. It sits between control logic (register file, sensor/loop controllers) and motor/LED/servo drive pins. It replaces single-channel fixed-period PWM instances.

---
 rtl/pwm_multi.sv | 160 ++++++++++++++++
 tb/tb_pwm_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator.
// One shared period counter feeds CHANNELS compare channels. It supports
// edge-aligned and center-aligned counting and per-channel output inversion.
// New settings are captured into a shadow set on load. They are copied into
// the active set only at a period boundary, so an update never produces a
// truncated or stretched pulse.
module pwm_multi #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] compare,
  input  logic                      center,
  input  logic [CHANNELS-1:0]       invert,
  input  logic                      load,
  output logic                      pending,
  output logic                      sync,
  output logic [CHANNELS-1:0]       m
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Shadow set: written by load, waits for the next boundary.
  logic [WIDTH-1:0]          sh_period_reg;
  logic [CHANNELS*WIDTH-1:0] sh_cmp_reg;
  logic                      sh_center_reg;
  logic [CHANNELS-1:0]       sh_invert_reg;

  // Active set: drives the counter and the compare channels.
  logic [WIDTH-1:0]          act_period_reg;
  logic [CHANNELS*WIDTH-1:0] act_cmp_reg;
  logic                      act_center_reg;
  logic [CHANNELS-1:0]       act_invert_reg;

  logic [WIDTH-1:0]          ctr_reg, ctr_next;
  logic                      dir_down_reg, dir_down_next;
  logic                      pending_reg, pending_next;
  logic                      sync_reg;
  logic [CHANNELS-1:0]       m_reg, m_next;
  logic                      boundary;
  logic                      transfer;

  // Boundary detection for the current count under the active settings.
  always_comb begin
    boundary = 1'b0;
    if (act_period_reg == '0) begin
      boundary = 1'b1;
    end else if (!act_center_reg) begin
      boundary = (ctr_reg == act_period_reg);
    end else begin
      // A center period of 1 has no descending phase, so it ends at the top.
      boundary = (dir_down_reg && (ctr_reg == ONE)) ||
                 ((ctr_reg == act_period_reg) && (act_period_reg <= ONE));
    end
  end

  assign transfer = boundary && pending_reg;

  // Counter and direction update. Every boundary restarts the count at 0 going up.
  always_comb begin
    ctr_next      = ctr_reg;
    dir_down_next = dir_down_reg;
    if (boundary) begin
      ctr_next      = '0;
      dir_down_next = 1'b0;
    end else if (!act_center_reg) begin
      ctr_next = ctr_reg + ONE;
    end else if (!dir_down_reg) begin
      if (ctr_reg == act_period_reg) begin
        ctr_next      = ctr_reg - ONE;
        dir_down_next = 1'b1;
      end else begin
        ctr_next = ctr_reg + ONE;
      end
    end else begin
      ctr_next = ctr_reg - ONE;
    end
  end

  // Pending flag. A load always leaves a set waiting; otherwise a boundary consumes it.
  always_comb begin
    pending_next = pending_reg;
    if (load) begin
      pending_next = 1'b1;
    end else if (boundary) begin
      pending_next = 1'b0;
    end
  end

  // Per-channel compare with optional inversion.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign m_next[gi] = (act_cmp_reg[gi*WIDTH +: WIDTH] > ctr_reg) ^ act_invert_reg[gi];
    end
  endgenerate

  // Shadow capture on load and the pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_period_reg <= '1;
      sh_cmp_reg    <= '0;
      sh_center_reg <= 1'b0;
      sh_invert_reg <= '0;
      pending_reg   <= 1'b0;
    end else begin
      if (load) begin
        sh_period_reg <= period;
        sh_cmp_reg    <= compare;
        sh_center_reg <= center;
        sh_invert_reg <= invert;
      end
      pending_reg <= pending_next;
    end
  end

  // Active set update. The copy uses the shadow value from before any same-cycle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_period_reg <= '1;
      act_cmp_reg    <= '0;
      act_center_reg <= 1'b0;
      act_invert_reg <= '0;
    end else if (transfer) begin
      act_period_reg <= sh_period_reg;
      act_cmp_reg    <= sh_cmp_reg;
      act_center_reg <= sh_center_reg;
      act_invert_reg <= sh_invert_reg;
    end
  end

  // Shared period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_reg      <= '0;
      dir_down_reg <= 1'b0;
    end else begin
      ctr_reg      <= ctr_next;
      dir_down_reg <= dir_down_next;
    end
  end

  // Registered outputs, one cycle behind the count they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg    <= '0;
      sync_reg <= 1'b0;
    end else begin
      m_reg    <= m_next;
      sync_reg <= boundary;
    end
  end

  assign m       = m_reg;
  assign sync    = sync_reg;
  assign pending = pending_reg;

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi. A phase-index model predicts m, sync and pending
// on every clock. Directed period scenarios also check hand-computed duty counts.
module tb_pwm_multi;

  localparam int W  = 12;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  period = '0;
  logic [CH*W-1:0] compare = '0;
  logic          center = 1'b0;
  logic [CH-1:0] invert = '0;
  logic          load = 1'b0;
  logic          pending;
  logic          sync;
  logic [CH-1:0] m;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk     (clk),
    .rst     (rst),
    .period  (period),
    .compare (compare),
    .center  (center),
    .invert  (invert),
    .load    (load),
    .pending (pending),
    .sync    (sync),
    .m       (m)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks the position t inside the current period.
  // It derives the count value and the boundary from the period length.
  int            md_t;
  logic [W-1:0]  a_per, s_per;
  logic [W-1:0]  a_cmp [CH];
  logic [W-1:0]  s_cmp [CH];
  logic          a_cen, s_cen, md_pend;
  logic [CH-1:0] a_inv, s_inv;
  logic [CH-1:0] exp_m;
  logic          exp_sync, exp_pend;

  initial begin
    int p, len, c;
    logic bnd;
    forever begin
      @(posedge clk);
      if (rst) begin
        md_t = 0; a_per = '1; s_per = '1; a_cen = 0; s_cen = 0;
        a_inv = '0; s_inv = '0; md_pend = 0;
        for (int i = 0; i < CH; i++) begin a_cmp[i] = '0; s_cmp[i] = '0; end
        exp_m = '0; exp_sync = 0; exp_pend = 0;
      end else begin
        p = int'(a_per);
        if (p == 0) len = 1;
        else if (a_cen) len = 2 * p;
        else len = p + 1;
        if (a_cen && md_t > p) c = 2 * p - md_t;
        else c = md_t;
        bnd = (md_t == len - 1);
        for (int i = 0; i < CH; i++) exp_m[i] = (int'(a_cmp[i]) > c) ^ a_inv[i];
        exp_sync = bnd;
        if (bnd) begin
          md_t = 0;
          if (md_pend) begin
            a_per = s_per; a_cen = s_cen; a_inv = s_inv;
            for (int i = 0; i < CH; i++) a_cmp[i] = s_cmp[i];
          end
        end else begin
          md_t++;
        end
        if (load) begin
          s_per = period; s_cen = center; s_inv = invert;
          for (int i = 0; i < CH; i++) s_cmp[i] = compare[i*W +: W];
          md_pend = 1;
        end else if (bnd) begin
          md_pend = 0;
        end
        exp_pend = md_pend;
      end
      #1;
      check("model_m", 32'(m), 32'(exp_m));
      check("model_sync", 32'(sync), 32'(exp_sync));
      check("model_pending", 32'(pending), 32'(exp_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  int          hi_cnt [CH];
  int          sync_cnt;
  logic        pend_mid, pend_end;
  logic [15:0] seq0;

  task automatic set_cfg(input int p, input int c0, input int c1, input int c2, input int c3,
                         input logic cen, input logic [CH-1:0] inv);
    period  = W'(p);
    compare = {W'(c3), W'(c2), W'(c1), W'(c0)};
    center  = cen;
    invert  = inv;
  endtask

  // Samples one period of outputs. A load strobe can be asserted at sample index ld_at.
  // A second strobe at ld2_at also rewrites channel 0's compare input to cmp2.
  task automatic run_period(input int len, input int ld_at, input int ld2_at, input logic [W-1:0] cmp2);
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    sync_cnt = 0; seq0 = '0; pend_mid = 0; pend_end = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) if (m[i]) hi_cnt[i]++;
      if (sync) sync_cnt++;
      if (k < 16) seq0[k] = m[0];
      if (k == len - 2) pend_mid = pending;
      if (k == len - 1) pend_end = pending;
      load = 1'b0;
      if (k == ld_at) load = 1'b1;
      if (k == ld2_at) begin compare[W-1:0] = cmp2; load = 1'b1; end
    end
    load = 1'b0;
    $display("period len=%0d: hi=%0d/%0d/%0d/%0d sync=%0d pend_mid=%0d pend_end=%0d seq0=%h",
             len, hi_cnt[0], hi_cnt[1], hi_cnt[2], hi_cnt[3], sync_cnt, pend_mid, pend_end, seq0);
  endtask

  task automatic wait_sync(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sync && cyc < max_cyc);
    $display("sync after %0d cycles", cyc);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_m", 32'(m), 0);
    check("reset_pending", 32'(pending), 0);
    check("reset_sync", 32'(sync), 0);
    wait_sync(5000, cyc);
    check("first_sync_4096", cyc, 4096);

    // Edge mode, P=9, one load, applied at the end of the 4096-cycle period.
    set_cfg(9, 3, 0, 10, 3, 1'b0, 4'b1000);
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    check("edge_pending_set", 32'(pending), 1);
    wait_sync(5000, cyc);
    check("edge_pending_clr", 32'(pending), 0);
    run_period(10, -1, -1, '0);
    check("edge_hi0", hi_cnt[0], 3);
    check("edge_hi1", hi_cnt[1], 0);
    check("edge_hi2", hi_cnt[2], 10);
    check("edge_hi3_inv", hi_cnt[3], 7);
    check("edge_sync_cnt", sync_cnt, 1);
    check("edge_seq0", 32'(seq0), 32'h0007);
    run_period(10, -1, -1, '0);
    check("edge_sync_cnt2", sync_cnt, 1);
    check("edge_hi0_2", hi_cnt[0], 3);

    // Center mode, P=4, cmp=2, then cmp=5.
    set_cfg(4, 2, 0, 0, 0, 1'b1, 4'b0000);
    run_period(10, 0, -1, '0);
    check("cen_load_pend_mid", 32'(pend_mid), 1);
    check("cen_load_pend_end", 32'(pend_end), 0);
    run_period(8, -1, -1, '0);
    check("cen_hi0_cmp2", hi_cnt[0], 3);
    check("cen_seq0_cmp2", 32'(seq0), 32'h0083);
    check("cen_sync_cnt", sync_cnt, 1);
    set_cfg(4, 5, 0, 0, 0, 1'b1, 4'b0000);
    run_period(8, 0, -1, '0);
    check("cen_hi0_before", hi_cnt[0], 3);
    run_period(8, -1, -1, '0);
    check("cen_hi0_cmp5", hi_cnt[0], 8);

    // Mid-period load: cmp 3 -> 7 at ctr=4.
    set_cfg(9, 3, 0, 0, 0, 1'b0, 4'b0000);
    run_period(8, 0, -1, '0);
    run_period(10, -1, -1, '0);
    check("mid_hi0_base", hi_cnt[0], 3);
    set_cfg(9, 7, 0, 0, 0, 1'b0, 4'b0000);
    run_period(10, 3, -1, '0);
    check("mid_hi0_old", hi_cnt[0], 3);
    check("mid_pend_mid", 32'(pend_mid), 1);
    check("mid_pend_end", 32'(pend_end), 0);
    run_period(10, -1, -1, '0);
    check("mid_hi0_new", hi_cnt[0], 7);

    // Load in the boundary cycle: 5 applies at this boundary, 2 at the next one.
    set_cfg(9, 5, 0, 0, 0, 1'b0, 4'b0000);
    run_period(10, 2, 8, W'(2));
    check("bnd_hi0_a", hi_cnt[0], 7);
    check("bnd_pend_mid", 32'(pend_mid), 1);
    check("bnd_pend_end", 32'(pend_end), 1);
    run_period(10, -1, -1, '0);
    check("bnd_hi0_b", hi_cnt[0], 5);
    check("bnd_pend_b", 32'(pend_end), 0);
    run_period(10, -1, -1, '0);
    check("bnd_hi0_c", hi_cnt[0], 2);

    // Reset mid-period with a pending set.
    set_cfg(9, 9, 9, 9, 9, 1'b0, 4'b1111);
    run_period(5, 1, -1, '0);
    check("rst_pend_before", 32'(pend_end), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_m", 32'(m), 0);
    check("rst_sync", 32'(sync), 0);
    check("rst_pending", 32'(pending), 0);
    wait_sync(5000, cyc);
    check("rst_sync_4096", cyc, 4096);
    run_period(10, -1, -1, '0);
    check("rst_hi0_discard", hi_cnt[0], 0);
    check("rst_hi3_discard", hi_cnt[3], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
